chngy_update_engine: RTL and testbench
======================================

CHNGY_UPDATE_ENGINE -- requirements
Module: chngy_update_engine

Interface
REQ-001 Parameter CW, default 24: signed width of each complex component; a complex word is 2*CW bits, real part in [2CW-1:CW], imaginary part in [CW-1:0].
REQ-002 Parameter DEPTH, default 4: output FIFO depth in entries; power of two, at least 2.
REQ-003 Parameter SAT, default 1: 1 = saturate results to CW bits; 0 = two's-complement wrap.
REQ-004 Parameter MAXT, default 15: maximum off-diagonal terms per row.
REQ-005 Ports, in order: clock in 1 (the only clock); reset in 1 (synchronous, active-high).
REQ-006 in_valid in 1: input transaction present.
REQ-007 in_ready out 1: engine accepts the input this cycle.
REQ-008 in_diag in 1: 1 = diagonal (row-closing) entry; 0 = off-diagonal entry.
REQ-009 in_yold in 2CW: current Y element.
REQ-010 in_delta in 2CW: change value for this element.
REQ-011 out_valid out 1: output entry present.
REQ-012 out_ready in 1: consumer takes the output entry.
REQ-013 out_y out 2CW: updated Y element.
REQ-014 out_diag out 1: entry closes a row.
REQ-015 out_ovf out 1: saturation or wrap occurred in this entry.
REQ-016 err_terms out 1: sticky flag; row term-count overflow.
REQ-017 busy out 1: a row is open, or data is in flight or in the FIFO.

Function
REQ-018 Accept an input on a cycle where in_valid=1 and in_ready=1, and only then.
REQ-019 Off-diagonal accept: result = in_yold - in_delta per component; acc += in_delta per component; term counter +1.
REQ-020 Diagonal accept: result = in_yold + acc + in_delta per component; acc and the term counter clear in the same cycle.
REQ-021 acc is CW+4 bits signed per component; final sums are computed at CW+5 bits, then saturated (SAT=1) or truncated (SAT=0) to CW.
REQ-022 out_ovf = 1 if either component's full-precision result is outside the signed CW range, for both SAT settings.
REQ-023 Row FSM has two states:
- IDLE (acc=0, count=0) -> OPEN on an off-diagonal accept.
- OPEN -> IDLE on a diagonal accept.
- IDLE + diagonal accept stays IDLE (acc=0 is used).
REQ-024 An off-diagonal accept when count=MAXT sets err_terms, is still processed, and the counter saturates at MAXT; err_terms clears only on reset.
REQ-025 Pipeline: stage 1 registers the operands and the acc snapshot; stage 2 registers the result and ovf and pushes to the FIFO. Accept-to-out_valid latency is 2 cycles when the FIFO is empty.
REQ-026 in_ready = (fifo_count + inflight) < DEPTH, where inflight counts occupied pipeline stages. in_ready has no combinational path from out_ready or in_valid.
REQ-027 FIFO is first-word-fall-through; out_* hold stable while out_valid=1 and out_ready=0.
REQ-028 Push and pop in the same cycle leave the count unchanged. Read and write pointers wrap modulo DEPTH.
REQ-029 Back-to-back off-diagonal accepts use the acc value updated by the previous accept (no stale accumulation).
REQ-030 busy = (state==OPEN) | inflight!=0 | fifo_count!=0.

Reset
REQ-031 reset=1 at a clock edge: out_valid=0, out_y=0, out_diag=0, out_ovf=0, err_terms=0, busy=0, acc=0, count=0, state=IDLE, FIFO empty, pipeline cleared.
REQ-032 Reset mid-row or mid-pipeline discards all open, in-flight and buffered data; in_ready=1 on the first cycle after reset deasserts.

Verification
REQ-033 CW=24, out_ready=1: off-diagonal accepts (yold=(100,50), delta=(10,-5)) and (yold=(7,7), delta=(3,2)), then diagonal (yold=(200,0), delta=(1,1)) -> out_y=(90,55), (4,5), (214,-2); out_diag=0,0,1; each output 2 cycles after its accept.
REQ-034 SAT=1, diagonal yold=(8388607,0), delta=(1,0) -> out_y real=8388607, out_ovf=1. With SAT=0 -> real=-8388608, out_ovf=1.
REQ-035 out_ready=0, inputs offered continuously -> exactly DEPTH accepts, then in_ready=0. Raising out_ready drains the entries in order, and in_ready returns the cycle after the first pop.
REQ-036 MAXT+1 off-diagonal accepts, then diagonal -> err_terms=1 from the (MAXT+1)th accept onward; the diagonal result includes all MAXT+1 deltas.
REQ-037 Reset asserted with an open row and 2 entries in the FIFO -> all outputs 0 next cycle. A following diagonal (yold=(5,5), delta=(0,0)) outputs (5,5).

Source files
------------

// File: rtl/chngy_update_engine.sv
// Incremental Y-matrix update engine: off-diagonal terms are applied and accumulated per row,
// and the diagonal entry closes the row with the accumulated sum. Results are queued in an output FIFO.
module chngy_update_engine #(
  parameter int CW    = 24,
  parameter int DEPTH = 4,
  parameter int SAT   = 1,
  parameter int MAXT  = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_diag,
  input  logic [2*CW-1:0] in_yold,
  input  logic [2*CW-1:0] in_delta,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*CW-1:0] out_y,
  output logic            out_diag,
  output logic            out_ovf,
  output logic            err_terms,
  output logic            busy
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(MAXT + 1);
  localparam int AccW = CW + 4;
  localparam int SumW = CW + 5;
  localparam logic signed [SumW-1:0] MaxV = {6'b000000, {(CW-1){1'b1}}};
  localparam logic signed [SumW-1:0] MinV = {6'b111111, {(CW-1){1'b0}}};

  typedef enum logic {IDLE, OPEN} rowState_t;

  rowState_t state, stateNext;
  logic signed [AccW-1:0] accRe, accIm, accReNext, accImNext;
  logic [CntW-1:0] termCount, termCountNext;
  logic errNext;

  logic s1Valid, s1Diag;
  logic signed [CW-1:0] s1YRe, s1YIm, s1DRe, s1DIm;
  logic signed [AccW-1:0] s1AccRe, s1AccIm;

  logic [2*CW+1:0] mem [DEPTH];
  logic [PtrW-1:0] wrPtr, rdPtr;
  logic [PtrW:0] fifoCount;
  logic [PtrW+1:0] occupancy;

  logic signed [CW-1:0] yRe, yIm, dRe, dIm;
  logic signed [SumW-1:0] sumRe, sumIm;
  logic [CW-1:0] resRe, resIm;
  logic resOvf, accept, push, pop;

  function automatic logic signed [SumW-1:0] extC(input logic signed [CW-1:0] v);
    return {{5{v[CW-1]}}, v};
  endfunction

  function automatic logic signed [SumW-1:0] extA(input logic signed [AccW-1:0] v);
    return {v[AccW-1], v};
  endfunction

  function automatic logic outOfRange(input logic signed [SumW-1:0] v);
    return (v > MaxV) || (v < MinV);
  endfunction

  function automatic logic [CW-1:0] fitCw(input logic signed [SumW-1:0] v);
    if (SAT != 0 && v > MaxV) return MaxV[CW-1:0];
    if (SAT != 0 && v < MinV) return MinV[CW-1:0];
    return v[CW-1:0];
  endfunction

  assign yRe = in_yold[2*CW-1:CW];
  assign yIm = in_yold[CW-1:0];
  assign dRe = in_delta[2*CW-1:CW];
  assign dIm = in_delta[CW-1:0];

  // Occupancy counts the stage-1 slot too, so a result never arrives at a full FIFO.
  assign occupancy = {1'b0, fifoCount} + {{(PtrW+1){1'b0}}, s1Valid};
  assign in_ready  = occupancy < (PtrW+2)'(DEPTH);
  assign accept    = in_valid & in_ready;
  assign push      = s1Valid;
  assign pop       = out_valid & out_ready;
  assign out_valid = fifoCount != '0;
  assign busy      = (state == OPEN) | s1Valid | (fifoCount != '0);
  assign {out_diag, out_ovf, out_y} = out_valid ? mem[rdPtr] : '0;

  // Row accumulator and term counter; a diagonal accept always returns the row to IDLE.
  always_comb begin
    stateNext     = state;
    accReNext     = accRe;
    accImNext     = accIm;
    termCountNext = termCount;
    errNext       = err_terms;
    if (accept) begin
      if (in_diag) begin
        stateNext     = IDLE;
        accReNext     = '0;
        accImNext     = '0;
        termCountNext = '0;
      end else begin
        stateNext = OPEN;
        accReNext = accRe + {{4{dRe[CW-1]}}, dRe};
        accImNext = accIm + {{4{dIm[CW-1]}}, dIm};
        if (termCount == CntW'(MAXT)) errNext = 1'b1;
        else termCountNext = termCount + CntW'(1);
      end
    end
  end

  // Stage 2 arithmetic: full precision first, then saturate or wrap to CW bits.
  always_comb begin
    if (s1Diag) begin
      sumRe = extC(s1YRe) + extA(s1AccRe) + extC(s1DRe);
      sumIm = extC(s1YIm) + extA(s1AccIm) + extC(s1DIm);
    end else begin
      sumRe = extC(s1YRe) - extC(s1DRe);
      sumIm = extC(s1YIm) - extC(s1DIm);
    end
    resRe  = fitCw(sumRe);
    resIm  = fitCw(sumIm);
    resOvf = outOfRange(sumRe) | outOfRange(sumIm);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      accRe     <= '0;
      accIm     <= '0;
      termCount <= '0;
      err_terms <= 1'b0;
      s1Valid   <= 1'b0;
      s1Diag    <= 1'b0;
      s1YRe     <= '0;
      s1YIm     <= '0;
      s1DRe     <= '0;
      s1DIm     <= '0;
      s1AccRe   <= '0;
      s1AccIm   <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      state     <= stateNext;
      accRe     <= accReNext;
      accIm     <= accImNext;
      termCount <= termCountNext;
      err_terms <= errNext;
      s1Valid   <= accept;
      if (accept) begin
        s1Diag  <= in_diag;
        s1YRe   <= yRe;
        s1YIm   <= yIm;
        s1DRe   <= dRe;
        s1DIm   <= dIm;
        s1AccRe <= accRe;
        s1AccIm <= accIm;
      end
      if (push) wrPtr <= wrPtr + PtrW'(1);
      if (pop)  rdPtr <= rdPtr + PtrW'(1);
      if (push && !pop)      fifoCount <= fifoCount + (PtrW+1)'(1);
      else if (pop && !push) fifoCount <= fifoCount - (PtrW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible through fifoCount.
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wrPtr] <= {s1Diag, resOvf, resRe, resIm};
  end

endmodule

// File: tb/tb_chngy_update_engine.sv
// Scoreboard bench for chngy_update_engine: a reference model queues expected results on each
// accept and compares them as entries leave the FIFO; a second SAT=0 instance checks wrap mode.
module tb_chngy_update_engine;

  localparam int CW    = 24;
  localparam int DEPTH = 4;
  localparam int MAXT  = 15;

  logic clock = 1'b0;
  logic reset, in_valid, in_diag, out_ready;
  logic [2*CW-1:0] in_yold, in_delta;
  logic in_ready, out_valid, out_diag, out_ovf, err_terms, busy;
  logic [2*CW-1:0] out_y;
  logic wInReady, wOutValid, wOutDiag, wOutOvf, wErrTerms, wBusy;
  logic [2*CW-1:0] wOutY;

  always #5 clock = ~clock;

  chngy_update_engine #(.CW(CW), .DEPTH(DEPTH), .SAT(1), .MAXT(MAXT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_diag(in_diag), .in_yold(in_yold), .in_delta(in_delta),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_diag(out_diag), .out_ovf(out_ovf), .err_terms(err_terms), .busy(busy));

  chngy_update_engine #(.CW(CW), .DEPTH(DEPTH), .SAT(0), .MAXT(MAXT)) dutWrap (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(wInReady),
    .in_diag(in_diag), .in_yold(in_yold), .in_delta(in_delta),
    .out_valid(wOutValid), .out_ready(out_ready), .out_y(wOutY),
    .out_diag(wOutDiag), .out_ovf(wOutOvf), .err_terms(wErrTerms), .busy(wBusy));

  typedef struct {
    logic [2*CW-1:0] y;
    logic diag;
    logic ovf;
    int acceptCycle;
  } expEntry_t;

  expEntry_t sbQ[$];
  expEntry_t expE, gotE;
  int checks = 0;
  int failures = 0;
  int cycle = 0;
  bit latencyCheck = 0;
  longint accRe, accIm, yr, yi, dr, di, fr, fi;
  int termCnt;
  logic errModel;
  logic [CW:0] rr, ri;

  always @(posedge clock) cycle++;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Returns {ovf, value} for a saturating CW-bit result.
  function automatic logic [CW:0] modelComp(input longint full);
    longint maxV = (longint'(1) <<< (CW - 1)) - 1;
    longint minV = -(longint'(1) <<< (CW - 1));
    logic [CW-1:0] v;
    if (full > maxV) v = maxV[CW-1:0];
    else if (full < minV) v = minV[CW-1:0];
    else v = full[CW-1:0];
    return {(full > maxV) || (full < minV), v};
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      sbQ.delete();
      accRe = 0; accIm = 0; termCnt = 0; errModel = 0;
    end else begin
      if (in_valid && in_ready) begin
        yr = longint'($signed(in_yold[2*CW-1:CW]));
        yi = longint'($signed(in_yold[CW-1:0]));
        dr = longint'($signed(in_delta[2*CW-1:CW]));
        di = longint'($signed(in_delta[CW-1:0]));
        if (in_diag) begin
          fr = yr + accRe + dr;
          fi = yi + accIm + di;
          accRe = 0; accIm = 0; termCnt = 0;
        end else begin
          fr = yr - dr;
          fi = yi - di;
          accRe += dr;
          accIm += di;
          if (termCnt == MAXT) errModel = 1;
          else termCnt++;
        end
        rr = modelComp(fr);
        ri = modelComp(fi);
        expE.y = {rr[CW-1:0], ri[CW-1:0]};
        expE.diag = in_diag;
        expE.ovf = rr[CW] | ri[CW];
        expE.acceptCycle = cycle;
        sbQ.push_back(expE);
      end
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) checkOutput("spuriousOut", 1, 0);
        else begin
          gotE = sbQ.pop_front();
          checkOutput("outY", out_y, gotE.y);
          checkOutput("outDiag", out_diag, gotE.diag);
          checkOutput("outOvf", out_ovf, gotE.ovf);
          if (latencyCheck) checkOutput("latency", cycle - gotE.acceptCycle, 2);
        end
      end
    end
  end

  task automatic syncDrive();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept with in_valid dropped.
  task automatic applyStimulus(input bit diag, input longint yRe, input longint yIm,
                               input longint dRe, input longint dIm);
    int w = 0;
    in_valid = 1'b1;
    in_diag  = diag;
    in_yold  = {CW'(yRe), CW'(yIm)};
    in_delta = {CW'(dRe), CW'(dIm)};
    while (1) begin
      @(negedge clock);
      if (in_ready) break;
      w++;
      if (w > 50) begin
        checkOutput("readyTimeout", 0, 1);
        break;
      end
    end
    syncDrive();
    in_valid = 1'b0;
  endtask

  initial begin
    int accepted;
    int w;
    reset = 1'b1; in_valid = 1'b0; in_diag = 1'b0;
    in_yold = '0; in_delta = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstOutY", out_y, 0);
    checkOutput("rstErr", err_terms, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReady", in_ready, 1);

    // Two back-to-back off-diagonal terms then the row-closing diagonal.
    latencyCheck = 1;
    applyStimulus(0, 100, 50, 10, -5);
    applyStimulus(0, 7, 7, 3, 2);
    applyStimulus(1, 200, 0, 1, 1);
    checkOutput("busyInFlight", busy, 1);
    repeat (4) syncDrive();
    latencyCheck = 0;
    checkOutput("idleAfterRow", busy, 0);

    applyStimulus(1, 8388607, 0, 1, 0);
    w = 0;
    while (!wOutValid && w < 10) begin
      @(negedge clock);
      w++;
    end
    checkOutput("wrapValid", wOutValid, 1);
    checkOutput("wrapRe", wOutY[2*CW-1:CW], 24'h800000);
    checkOutput("wrapOvf", wOutOvf, 1);

    // Fill with the consumer stalled, then release it.
    syncDrive();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_diag = 1'b0;
    in_delta = {CW'(1), CW'(1)};
    accepted = 0;
    in_yold = {CW'(0), CW'(0)};
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (in_ready) accepted++;
      syncDrive();
      in_yold = {CW'(accepted * 10), CW'(accepted)};
    end
    in_valid = 1'b0;
    checkOutput("fillAccepts", accepted, DEPTH);
    checkOutput("fullNotReady", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("readyBeforePop", in_ready, 0);
    @(negedge clock);
    checkOutput("readyAfterPop", in_ready, 1);
    repeat (6) syncDrive();
    applyStimulus(1, 0, 0, 0, 0);

    // One term past the limit.
    for (int i = 0; i <= MAXT; i++) begin
      applyStimulus(0, 0, 0, i + 1, -(i + 1));
      checkOutput("errTerms", err_terms, (i >= MAXT) ? 1 : 0);
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("errSticky", err_terms, 1);
    repeat (4) syncDrive();

    // Reset with an open row and two buffered entries.
    out_ready = 1'b0;
    applyStimulus(0, 1, 2, 3, 4);
    applyStimulus(0, 5, 6, 7, 8);
    repeat (3) syncDrive();
    checkOutput("preRstValid", out_valid, 1);
    reset = 1'b1;
    syncDrive();
    reset = 1'b0;
    checkOutput("midRstValid", out_valid, 0);
    checkOutput("midRstY", out_y, 0);
    checkOutput("midRstDiag", out_diag, 0);
    checkOutput("midRstOvf", out_ovf, 0);
    checkOutput("midRstErr", err_terms, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstReady", in_ready, 1);
    out_ready = 1'b1;
    applyStimulus(1, 5, 5, 0, 0);

    w = 0;
    while (sbQ.size() != 0 && w < 50) begin
      @(posedge clock);
      w++;
    end
    #1;
    checkOutput("sbDrained", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
